// File: rtl/replica_pkg.sv
// Shared replica-level types: or-opt proposal record, move commands,
// tour-delta type and the or_delta sequencing states.
package replica_pkg;

    localparam int city_num = 8;
    localparam int city_w   = $clog2(city_num);
    localparam int dist_w   = 16;
    localparam int base_w   = 4;
    localparam int rmet_w   = 16;
    localparam int rexc_w   = 8;

    // Move command carried by every proposal: THR passes straight through.
    typedef enum logic [0:0] {
        THR = 1'b0,
        OR1 = 1'b1
    } com_t;

    typedef struct packed {
        com_t              com;
        logic [base_w-1:0] base_id;
        logic [city_w-1:0] k;
        logic [city_w-1:0] l;
        logic [rmet_w-1:0] r_metropolis;
        logic [rexc_w-1:0] r_exchange;
    } opt_t;

    // Signed tour-length delta; three guard bits hold +-3 full-scale edges.
    typedef logic signed [dist_w+2:0] delta_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PATH  = 3'd1,
        DIST  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } or_delta_state_t;

endpackage

// File: rtl/or_delta_chk.sv
// Simulation checker: accepted or-opt proposals must describe a legal move.
module or_delta_chk #(
    parameter int CITY_NUM = 8,
    parameter int CITY_W   = $clog2(CITY_NUM)
) (
    input logic              clk,
    input logic              reset,
    input logic              check_i,
    input logic [CITY_W-1:0] k_i,
    input logic [CITY_W-1:0] l_i
);

    logic legal_s;

    assign legal_s = (k_i != '0) && (int'(k_i) < CITY_NUM) && (int'(l_i) < CITY_NUM)
                     && (k_i != l_i) && (int'(k_i) != int'(l_i) + 1);

    a_legal_move: assert property (@(posedge clk) disable iff (reset) check_i |-> legal_s);

endmodule

// File: rtl/or_delta_dist_accum.sv
// Signed accumulator for edge lengths: clear has priority, each enabled
// input is zero-extended and either added or subtracted.
module dist_accum
    import replica_pkg::*;
#(
    parameter int DIST_W = dist_w
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     en,
    input  logic                     sub,
    input  logic [DIST_W-1:0]        din,
    output logic signed [DIST_W+2:0] acc
);

    logic signed [DIST_W+2:0] acc_q;
    logic signed [DIST_W+2:0] acc_d;
    logic signed [DIST_W+2:0] ext_s;

    // Next accumulator value from clear/enable/sign controls.
    always_comb begin
        ext_s = $signed({3'b000, din});
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (en) begin
            if (sub) begin
                acc_d = acc_q - ext_s;
            end else begin
                acc_d = acc_q + ext_s;
            end
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/or_delta.sv
// Or-opt tour-length delta: reads the five affected cities from the tour
// RAM, the six affected edges from the distance RAM, and reports
// new_len - old_len with a fixed 13-cycle latency (1 cycle for THR).
module or_delta
    import replica_pkg::*;
#(
    parameter int CITY_NUM = city_num,
    parameter int CITY_W   = $clog2(CITY_NUM),
    parameter int DIST_W   = dist_w
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     run_i,
    input  opt_t                     opt_i,
    output logic                     busy,
    output logic                     path_re,
    output logic [CITY_W-1:0]        path_raddr,
    input  logic [CITY_W-1:0]        path_rdata,
    output logic                     dist_re,
    output logic [2*CITY_W-1:0]      dist_raddr,
    input  logic [DIST_W-1:0]        dist_rdata,
    output logic                     run_o,
    output opt_t                     opt_o,
    output logic signed [DIST_W+2:0] delta_o
);

    or_delta_state_t state_q, state_d;
    logic [2:0]           step_q, step_d, step_inc_s;
    logic                 busy_q, busy_d;
    logic                 run_o_q, run_o_d;
    logic                 path_re_q, path_re_d;
    logic [CITY_W-1:0]    path_raddr_q, path_raddr_d;
    logic                 dist_re_q, dist_re_d;
    logic [2*CITY_W-1:0]  dist_raddr_q, dist_raddr_d;
    opt_t                 opt_q, opt_d;
    logic                 rex_cap_q, rex_cap_d;
    logic                 rd_vld_q, rd_vld_d;
    logic [2:0]           rd_idx_q, rd_idx_d;
    logic [4:0][CITY_W-1:0]   p_q, p_d;
    logic                 acc_en_q, acc_en_d;
    logic                 acc_sub_q, acc_sub_d;
    logic                 accept_s;
    logic                 acc_clr_s;
    logic [4:0][CITY_W-1:0]   path_addr_s;
    logic [5:0][2*CITY_W-1:0] edge_s;

    function automatic logic [CITY_W-1:0] wrap_inc(input logic [CITY_W-1:0] pos);
        if (int'(pos) == CITY_NUM - 1) begin
            return '0;
        end else begin
            return pos + CITY_W'(1);
        end
    endfunction

    // A proposal is taken in IDLE, or in DONE since that cycle returns to IDLE.
    assign accept_s   = run_i && ((state_q == IDLE) || (state_q == DONE));
    assign step_inc_s = step_q + 3'd1;
    assign acc_clr_s  = (accept_s && (opt_i.com == THR)) || ((state_q == DIST) && (step_q == 3'd0));

    // Tour positions to read and edges to fetch, in issue order.
    always_comb begin
        path_addr_s[0] = opt_q.k - CITY_W'(1);
        path_addr_s[1] = opt_q.k;
        path_addr_s[2] = wrap_inc(opt_q.k);
        path_addr_s[3] = opt_q.l;
        path_addr_s[4] = wrap_inc(opt_q.l);
        edge_s[0] = {p_q[0], p_q[1]};
        edge_s[1] = {p_q[1], p_q[2]};
        edge_s[2] = {p_q[3], p_q[4]};
        edge_s[3] = {p_q[0], p_q[2]};
        edge_s[4] = {p_q[3], p_q[1]};
        edge_s[5] = {p_q[1], p_q[4]};
    end

    // Sequencer: capture, path reads, distance reads, drain, result strobe.
    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        run_o_d      = 1'b0;
        path_re_d    = 1'b0;
        path_raddr_d = path_raddr_q;
        dist_re_d    = 1'b0;
        dist_raddr_d = dist_raddr_q;
        rex_cap_d    = 1'b0;
        opt_d        = opt_q;
        if (rex_cap_q) begin
            opt_d.r_exchange = opt_i.r_exchange;
        end else begin
            opt_d.r_exchange = opt_q.r_exchange;
        end
        case (state_q)
            IDLE, DONE: begin
                if (accept_s) begin
                    opt_d     = opt_i;
                    rex_cap_d = 1'b1;
                    step_d    = 3'd0;
                    if (opt_i.com == OR1) begin
                        state_d      = PATH;
                        path_re_d    = 1'b1;
                        path_raddr_d = opt_i.k - CITY_W'(1);
                    end else begin
                        state_d = DONE;
                        run_o_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            PATH: begin
                if (step_q == 3'd4) begin
                    state_d      = DIST;
                    step_d       = 3'd0;
                    dist_re_d    = 1'b1;
                    dist_raddr_d = edge_s[0];
                end else begin
                    step_d       = step_inc_s;
                    path_re_d    = 1'b1;
                    path_raddr_d = path_addr_s[step_inc_s];
                end
            end
            DIST: begin
                if (step_q == 3'd5) begin
                    state_d = DRAIN;
                    step_d  = 3'd0;
                end else begin
                    step_d       = step_inc_s;
                    dist_re_d    = 1'b1;
                    dist_raddr_d = edge_s[step_inc_s];
                end
            end
            DRAIN: begin
                state_d = DONE;
                run_o_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d    = (state_d != IDLE);
        acc_en_d  = dist_re_q;
        acc_sub_d = (state_q == DIST) && (step_q < 3'd3);
    end

    // Registers the tour RAM's returned cities in arrival order.
    always_comb begin
        p_d      = p_q;
        rd_vld_d = path_re_q;
        rd_idx_d = rd_idx_q;
        if (accept_s) begin
            rd_idx_d = 3'd0;
        end else if (rd_vld_q) begin
            p_d[rd_idx_q] = path_rdata;
            rd_idx_d      = rd_idx_q + 3'd1;
        end else begin
            rd_idx_d = rd_idx_q;
        end
    end

    // State, outputs and captured data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            step_q       <= 3'd0;
            busy_q       <= 1'b0;
            run_o_q      <= 1'b0;
            path_re_q    <= 1'b0;
            path_raddr_q <= '0;
            dist_re_q    <= 1'b0;
            dist_raddr_q <= '0;
            opt_q        <= '0;
            opt_q.com    <= THR;
            rex_cap_q    <= 1'b0;
            rd_vld_q     <= 1'b0;
            rd_idx_q     <= 3'd0;
            p_q          <= '0;
            acc_en_q     <= 1'b0;
            acc_sub_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            busy_q       <= busy_d;
            run_o_q      <= run_o_d;
            path_re_q    <= path_re_d;
            path_raddr_q <= path_raddr_d;
            dist_re_q    <= dist_re_d;
            dist_raddr_q <= dist_raddr_d;
            opt_q        <= opt_d;
            rex_cap_q    <= rex_cap_d;
            rd_vld_q     <= rd_vld_d;
            rd_idx_q     <= rd_idx_d;
            p_q          <= p_d;
            acc_en_q     <= acc_en_d;
            acc_sub_q    <= acc_sub_d;
        end
    end

    dist_accum #(.DIST_W(DIST_W)) u_accum (
        .clk   (clk),
        .reset (reset),
        .clear (acc_clr_s),
        .en    (acc_en_q),
        .sub   (acc_sub_q),
        .din   (dist_rdata),
        .acc   (delta_o)
    );

    or_delta_chk #(.CITY_NUM(CITY_NUM), .CITY_W(CITY_W)) u_chk (
        .clk     (clk),
        .reset   (reset),
        .check_i (accept_s && (opt_i.com == OR1)),
        .k_i     (opt_i.k),
        .l_i     (opt_i.l)
    );

    assign busy       = busy_q;
    assign run_o      = run_o_q;
    assign path_re    = path_re_q;
    assign path_raddr = path_raddr_q;
    assign dist_re    = dist_re_q;
    assign dist_raddr = dist_raddr_q;
    assign opt_o      = opt_q;

endmodule

// File: tb/tb_or_delta.sv
// Bench for or_delta: table of directed moves, hand-written timing
// sequences, and random moves checked against a whole-tour length model.
module tb_or_delta;
    import replica_pkg::*;

    localparam int N  = city_num;
    localparam int CW = city_w;
    localparam int DW = dist_w;

    typedef struct {
        string nm;
        com_t  com;
        int    k;
        int    l;
        int    exp_delta;
        int    exp_lat;
        int    n_addr;
        int    addr[5];
    } vec_t;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 run_i;
    opt_t                 opt_i;
    logic                 busy;
    logic                 path_re;
    logic [CW-1:0]        path_raddr;
    logic [CW-1:0]        path_rdata = '0;
    logic                 dist_re;
    logic [2*CW-1:0]      dist_raddr;
    logic [DW-1:0]        dist_rdata = '0;
    logic                 run_o;
    opt_t                 opt_o;
    logic signed [DW+2:0] delta_o;

    logic [CW-1:0] tour [N];
    logic [DW-1:0] dmat [N][N];

    int n_checks = 0;
    int n_fail   = 0;

    or_delta dut (
        .clk        (clk),
        .reset      (reset),
        .run_i      (run_i),
        .opt_i      (opt_i),
        .busy       (busy),
        .path_re    (path_re),
        .path_raddr (path_raddr),
        .path_rdata (path_rdata),
        .dist_re    (dist_re),
        .dist_raddr (dist_raddr),
        .dist_rdata (dist_rdata),
        .run_o      (run_o),
        .opt_o      (opt_o),
        .delta_o    (delta_o)
    );

    // Clock.
    always #5 clk = ~clk;

    // Tour and distance RAMs with one cycle of read latency.
    always @(posedge clk) begin
        if (path_re) path_rdata <= tour[path_raddr];
        if (dist_re) dist_rdata <= dmat[dist_raddr[2*CW-1:CW]][dist_raddr[CW-1:0]];
    end

    // Safety net against a hung run.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic opt_t mk(input com_t c, input int k, input int l, input int base);
        opt_t o;
        o = '0;
        o.com          = c;
        o.base_id      = base_w'(base);
        o.k            = CW'(k);
        o.l            = CW'(l);
        o.r_metropolis = rmet_w'($urandom);
        o.r_exchange   = 8'h55;
        return o;
    endfunction

    function automatic vec_t mkvec(input string nm, input com_t c, input int k, input int l,
                                   input int d, input int a0, input int a1, input int a2,
                                   input int a3, input int a4);
        vec_t v;
        v.nm = nm; v.com = c; v.k = k; v.l = l; v.exp_delta = d;
        v.exp_lat = (c == OR1) ? 13 : 1;
        v.n_addr  = (c == OR1) ? 5 : 0;
        v.addr[0] = a0; v.addr[1] = a1; v.addr[2] = a2; v.addr[3] = a3; v.addr[4] = a4;
        return v;
    endfunction

    // Closed directed tour length of an explicit city sequence.
    function automatic int tour_len(input int t[N]);
        int s = 0;
        for (int i = 0; i < N; i++) s += int'(dmat[t[i]][t[(i + 1) % N]]);
        return s;
    endfunction

    // Build the moved tour explicitly and difference the two full lengths.
    function automatic int model_delta(input int k, input int l);
        int old_t[N];
        int new_t[N];
        int rest[$];
        int ins;
        for (int i = 0; i < N; i++) old_t[i] = int'(tour[i]);
        for (int i = 0; i < N; i++) if (i != k) rest.push_back(old_t[i]);
        ins = (l < k) ? l + 1 : l;
        rest.insert(ins, old_t[k]);
        for (int i = 0; i < N; i++) new_t[i] = rest[i];
        return tour_len(new_t) - tour_len(old_t);
    endfunction

    task automatic set_linear();
        for (int a = 0; a < N; a++) begin
            tour[a] = CW'(a);
            for (int b = 0; b < N; b++) dmat[a][b] = DW'((a > b) ? a - b : b - a);
        end
    endtask

    task automatic do_run(input vec_t v, input int base);
        opt_t o;
        int   got;
        int   nd;
        int   addrs[$];
        int   d_seen;
        o = mk(v.com, v.k, v.l, base);
        @(negedge clk);
        run_i = 1'b1;
        opt_i = o;
        got = 0;
        nd  = 0;
        for (int c = 1; c <= 40 && got == 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                run_i = 1'b0;
                opt_i.r_exchange = 8'hAA;
                chk({v.nm, ".busy_t1"}, int'(busy), 1);
            end
            if (path_re) addrs.push_back(int'(path_raddr));
            if (dist_re) nd++;
            if (run_o) got = c;
        end
        chk({v.nm, ".latency"}, got, v.exp_lat);
        chk({v.nm, ".n_path_reads"}, addrs.size(), v.n_addr);
        for (int i = 0; i < addrs.size() && i < 5; i++) chk({v.nm, ".path_addr"}, addrs[i], v.addr[i]);
        chk({v.nm, ".n_dist_reads"}, nd, (v.com == OR1) ? 6 : 0);
        if (got != 0) begin
            chk({v.nm, ".delta"}, int'(delta_o), v.exp_delta);
            chk({v.nm, ".busy_at_run_o"}, int'(busy), 1);
            chk({v.nm, ".com"}, int'(opt_o.com), int'(v.com));
            chk({v.nm, ".base_id"}, int'(opt_o.base_id), base);
            chk({v.nm, ".k"}, int'(opt_o.k), v.k);
            chk({v.nm, ".l"}, int'(opt_o.l), v.l);
            chk({v.nm, ".r_exchange"}, int'(opt_o.r_exchange), (v.com == OR1) ? 8'hAA : 8'h55);
        end
        d_seen = int'(delta_o);
        @(negedge clk);
        chk({v.nm, ".run_o_single"}, int'(run_o), 0);
        chk({v.nm, ".busy_after"}, int'(busy), 0);
        chk({v.nm, ".delta_held"}, int'(delta_o), v.exp_delta);
        chk({v.nm, ".r_exchange_after"}, int'(opt_o.r_exchange), 8'hAA);
        if (d_seen != v.exp_delta) chk({v.nm, ".delta_stable"}, int'(delta_o), d_seen);
    endtask

    vec_t tbl[7];

    // Main sequence.
    initial begin
        int   nrun;
        int   first;
        int   second;
        vec_t v;
        int   k;
        int   l;
        int   j;
        logic [CW-1:0] tmp;

        reset = 1'b1;
        run_i = 1'b0;
        opt_i = '0;
        set_linear();
        repeat (3) @(negedge clk);

        chk("rst.busy", int'(busy), 0);
        chk("rst.run_o", int'(run_o), 0);
        chk("rst.path_re", int'(path_re), 0);
        chk("rst.dist_re", int'(dist_re), 0);
        chk("rst.delta", int'(delta_o), 0);
        chk("rst.com", int'(opt_o.com), int'(THR));
        chk("rst.path_raddr", int'(path_raddr), 0);
        chk("rst.dist_raddr", int'(dist_raddr), 0);
        reset = 1'b0;

        tbl[0] = mkvec("or_k3_l5", OR1, 3, 5,  4, 2, 3, 4, 5, 6);
        tbl[1] = mkvec("or_k7_l2", OR1, 7, 2,  6, 6, 7, 0, 2, 3);
        tbl[2] = mkvec("or_k3_l7", OR1, 3, 7,  0, 2, 3, 4, 7, 0);
        tbl[3] = mkvec("thr",      THR, 3, 5,  0, 0, 0, 0, 0, 0);
        tbl[4] = mkvec("or_k1_l2", OR1, 1, 2,  2, 0, 1, 2, 2, 3);
        tbl[5] = mkvec("or_k5_l1", OR1, 5, 1,  6, 4, 5, 6, 1, 2);
        tbl[6] = mkvec("or_k6_l0", OR1, 6, 0, 10, 5, 6, 7, 0, 1);
        for (int i = 0; i < 7; i++) do_run(tbl[i], i + 2);

        // Second run_i while busy is ignored.
        @(negedge clk);
        run_i = 1'b1;
        opt_i = mk(OR1, 3, 5, 1);
        nrun = 0; first = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            run_i = (c == 4);
            if (c == 4) opt_i = mk(OR1, 5, 1, 9);
            if (run_o) begin
                nrun++;
                if (first == 0) first = c;
                chk("busy_ign.delta", int'(delta_o), 4);
                chk("busy_ign.base_id", int'(opt_o.base_id), 1);
                chk("busy_ign.k", int'(opt_o.k), 3);
            end
        end
        chk("busy_ign.n_run_o", nrun, 1);
        chk("busy_ign.latency", first, 13);

        // Reset at T+8 aborts; a proposal at T+10 completes at T+23.
        @(negedge clk);
        run_i = 1'b1;
        opt_i = mk(OR1, 3, 5, 3);
        nrun = 0; first = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            run_i = 1'b0;
            if (c == 8) reset = 1'b1;
            if (c == 9) begin
                chk("abort.busy", int'(busy), 0);
                chk("abort.run_o", int'(run_o), 0);
                chk("abort.path_re", int'(path_re), 0);
                chk("abort.dist_re", int'(dist_re), 0);
                reset = 1'b0;
            end
            if (c == 10) begin
                run_i = 1'b1;
                opt_i = mk(OR1, 7, 2, 5);
            end
            if (run_o) begin
                nrun++;
                if (first == 0) first = c;
                chk("abort.delta", int'(delta_o), 6);
                chk("abort.base_id", int'(opt_o.base_id), 5);
            end
        end
        chk("abort.n_run_o", nrun, 1);
        chk("abort.run_o_cycle", first, 23);

        // run_i in the DONE cycle is accepted.
        @(negedge clk);
        run_i = 1'b1;
        opt_i = mk(OR1, 3, 5, 6);
        nrun = 0; first = 0; second = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            run_i = 1'b0;
            if (run_o) begin
                nrun++;
                if (first == 0) begin
                    first = c;
                    chk("b2b.delta_a", int'(delta_o), 4);
                    run_i = 1'b1;
                    opt_i = mk(OR1, 7, 2, 7);
                end else begin
                    second = c;
                    chk("b2b.delta_b", int'(delta_o), 6);
                    chk("b2b.base_id_b", int'(opt_o.base_id), 7);
                end
            end
        end
        chk("b2b.n_run_o", nrun, 2);
        chk("b2b.first", first, 13);
        chk("b2b.second", second, 26);

        // Random tours, asymmetric distances and legal moves.
        for (int it = 0; it < 24; it++) begin
            for (int a = 0; a < N; a++) tour[a] = CW'(a);
            for (int a = N - 1; a > 0; a--) begin
                j = int'($urandom_range(0, a));
                tmp = tour[a]; tour[a] = tour[j]; tour[j] = tmp;
            end
            for (int a = 0; a < N; a++)
                for (int b = 0; b < N; b++)
                    dmat[a][b] = ($urandom_range(0, 3) == 0) ? {DW{1'b1}} : DW'($urandom);
            k = int'($urandom_range(1, N - 1));
            l = int'($urandom_range(0, N - 1));
            while (l == k || k == l + 1) l = int'($urandom_range(0, N - 1));
            v = mkvec("rand", OR1, k, l, model_delta(k, l),
                      k - 1, k, (k + 1) % N, l, (l + 1) % N);
            do_run(v, it % 16);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
